// File: rtl/au_sub_cz.sv
// Registered WIDTH-bit subtractor s = a - b - ci with borrow-out and zero flag.
// ARCH picks the borrow network; define AU_SUB_CZ_ZFULL_EN for an exact (s == 0) zero flag.
module au_sub_cz #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             z
);

  localparam int NL = $clog2(WIDTH);

  // w_bor[i] is the borrow into bit i; w_bor[WIDTH] is the borrow-out
  logic [WIDTH:0]   w_bor;
  logic [WIDTH-1:0] w_s;
  logic             w_co;
  logic             w_z;

  // Bit i generates a borrow when a=0,b=1 and passes one through when a==b.
  // The borrow-in is folded into bit 0 so every prefix already includes ci.
  if (ARCH == 1) begin : g_sklansky
    always_comb begin : p_pfx
      logic [WIDTH-1:0] g, p, gp, pp;
      int j;
      g    = ~a & b;
      p    = ~(a ^ b);
      g[0] = g[0] | (p[0] & ci);
      for (int l = 0; l < NL; l++) begin
        gp = g;
        pp = p;
        for (int i = 0; i < WIDTH; i++) begin
          if (((i >> l) & 1) == 1) begin
            j    = ((i >> l) << l) - 1;
            g[i] = gp[i] | (pp[i] & gp[j]);
            p[i] = pp[i] & pp[j];
          end
        end
      end
      w_bor = {g, ci};
    end
  end else if (ARCH == 2) begin : g_kogge_stone
    always_comb begin : p_pfx
      logic [WIDTH-1:0] g, p, gp, pp;
      g    = ~a & b;
      p    = ~(a ^ b);
      g[0] = g[0] | (p[0] & ci);
      for (int l = 0; l < NL; l++) begin
        gp = g;
        pp = p;
        for (int i = 0; i < WIDTH; i++) begin
          if (i >= (1 << l)) begin
            g[i] = gp[i] | (pp[i] & gp[i - (1 << l)]);
            p[i] = pp[i] & pp[i - (1 << l)];
          end
        end
      end
      w_bor = {g, ci};
    end
  end else if (ARCH == 3) begin : g_brent_kung
    always_comb begin : p_pfx
      logic [WIDTH-1:0] g, p, gp, pp;
      g    = ~a & b;
      p    = ~(a ^ b);
      g[0] = g[0] | (p[0] & ci);
      // up-sweep builds power-of-two group terms, down-sweep fills the gaps
      for (int l = 0; l < NL; l++) begin
        gp = g;
        pp = p;
        for (int i = 0; i < WIDTH; i++) begin
          if (((i + 1) % (2 << l)) == 0) begin
            g[i] = gp[i] | (pp[i] & gp[i - (1 << l)]);
            p[i] = pp[i] & pp[i - (1 << l)];
          end
        end
      end
      for (int l = NL - 1; l >= 0; l--) begin
        gp = g;
        pp = p;
        for (int i = 0; i < WIDTH; i++) begin
          if ((((i + 1) % (2 << l)) == (1 << l)) && (i > (1 << l))) begin
            g[i] = gp[i] | (pp[i] & gp[i - (1 << l)]);
            p[i] = pp[i] & pp[i - (1 << l)];
          end
        end
      end
      w_bor = {g, ci};
    end
  end else begin : g_ripple
    always_comb begin : p_pfx
      logic [WIDTH-1:0] g, p;
      g    = ~a & b;
      p    = ~(a ^ b);
      g[0] = g[0] | (p[0] & ci);
      for (int i = 1; i < WIDTH; i++) begin
        g[i] = g[i] | (p[i] & g[i-1]);
      end
      w_bor = {g, ci};
    end
  end

  assign w_s  = a ^ b ^ w_bor[WIDTH-1:0];
  assign w_co = w_bor[WIDTH];

`ifdef AU_SUB_CZ_ZFULL_EN
  assign w_z = ~|w_s;
`else
  // equality tree kept off the borrow path
  assign w_z = ~|(a ^ b);
`endif

  // output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s  <= '0;
      co <= 1'b0;
      z  <= 1'b1;
    end else begin
      s  <= w_s;
      co <= w_co;
      z  <= w_z;
    end
  end

endmodule

// File: tb/tb_au_sub_cz.sv
// Bench for au_sub_cz: directed table, exhaustive 8-bit sweep, wide random vectors, reset pulses.
module tb_au_sub_cz;

`ifdef AU_SUB_CZ_ZFULL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  a8, b8;
  logic        ci8 [4];
  logic [7:0]  s8  [4];
  logic        co8 [4];
  logic        z8  [4];
  logic [63:0] a64, b64;
  logic        ci64;
  logic [31:0] s32 [4];
  logic        co32 [4];
  logic        z32  [4];
  logic [63:0] s64 [4];
  logic        co64 [4];
  logic        z64  [4];

  int total = 0;
  int bad   = 0;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    au_sub_cz #(.WIDTH(8), .ARCH(k)) u8 (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .ci(ci8[k]),
      .s(s8[k]), .co(co8[k]), .z(z8[k]));
    au_sub_cz #(.WIDTH(32), .ARCH(k + 4 * (k / 3))) u32 (
      .clk(clk), .rst(rst), .a(a64[31:0]), .b(b64[31:0]), .ci(ci64),
      .s(s32[k]), .co(co32[k]), .z(z32[k]));
    au_sub_cz #(.WIDTH(64), .ARCH(k)) u64 (
      .clk(clk), .rst(rst), .a(a64), .b(b64), .ci(ci64),
      .s(s64[k]), .co(co64[k]), .z(z64[k]));
  end

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference: full-precision difference, borrow as an unsigned comparison.
  task automatic model_chk(input string nm, input int w, input logic [63:0] a, input logic [63:0] b,
                           input logic ci, input logic [63:0] s, input logic co, input logic z);
    logic [63:0]  mask, es;
    logic [127:0] d;
    logic         eco, ez;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    d    = {64'd0, a & mask} - {64'd0, b & mask} - {127'd0, ci};
    es   = d[63:0] & mask;
    eco  = ({64'd0, a & mask} < ({64'd0, b & mask} + {127'd0, ci}));
    ez   = ZF ? (es == 64'd0) : ((a & mask) == (b & mask));
    cmp({nm, ".s"}, s & mask, es);
    cmp({nm, ".co"}, {63'd0, co}, {63'd0, eco});
    if (ci == 1'b0 || ZF) cmp({nm, ".z"}, {63'd0, z}, {63'd0, ez});
  endtask

  task automatic chk_reset_vals(input string nm);
    for (int k = 0; k < 4; k++) begin
      cmp({nm, ".s8"},  {56'd0, s8[k]}, 64'd0);
      cmp({nm, ".co8"}, {63'd0, co8[k]}, 64'd0);
      cmp({nm, ".z8"},  {63'd0, z8[k]}, 64'd1);
      cmp({nm, ".s64"}, s64[k], 64'd0);
      cmp({nm, ".z32"}, {63'd0, z32[k]}, 64'd1);
    end
  endtask

  task automatic chk_all();
    for (int k = 0; k < 4; k++) begin
      model_chk($sformatf("w8a%0d", k), 8, {56'd0, a8}, {56'd0, b8}, ci8[k], {56'd0, s8[k]}, co8[k], z8[k]);
      model_chk($sformatf("w32i%0d", k), 32, a64, b64, ci64, {32'd0, s32[k]}, co32[k], z32[k]);
      model_chk($sformatf("w64a%0d", k), 64, a64, b64, ci64, s64[k], co64[k], z64[k]);
    end
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       ci;
    logic [7:0] s;
    logic       co, z;
  } vec_t;
  vec_t tbl [8];

  initial begin
    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, ZF};
    tbl[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[4] = '{8'h7A, 8'h7A, 1'b1, 8'hFF, 1'b1, !ZF};
    tbl[5] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[6] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[7] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, ZF};

    // reset applied mid-cycle with non-zero operands
    rst = 1'b0; a8 = 8'hFF; b8 = 8'h01; a64 = '1; b64 = 64'd1; ci64 = 1'b1;
    for (int k = 0; k < 4; k++) ci8[k] = 1'b1;
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_now");
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_reset_vals("rst_hold");
    rst = 1'b0;

    // directed table, back-to-back
    foreach (tbl[n]) begin
      a8 = tbl[n].a; b8 = tbl[n].b;
      for (int k = 0; k < 4; k++) ci8[k] = tbl[n].ci;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        cmp($sformatf("tbl%0d.a%0d.s", n, k),  {56'd0, s8[k]}, {56'd0, tbl[n].s});
        cmp($sformatf("tbl%0d.a%0d.co", n, k), {63'd0, co8[k]}, {63'd0, tbl[n].co});
        cmp($sformatf("tbl%0d.a%0d.z", n, k),  {63'd0, z8[k]}, {63'd0, tbl[n].z});
      end
    end

    // exhaustive 8-bit sweep; odd ARCH instances run with ci=1, even with ci=0
    for (int n = 0; n < 65536; n++) begin
      a8 = n[15:8]; b8 = n[7:0];
      a64 = {8{n[15:8]}}; b64 = {8{n[7:0]}}; ci64 = n[0];
      for (int k = 0; k < 4; k++) ci8[k] = k[0];
      @(posedge clk); #1;
      chk_all();
    end

    // all-zero / all-one corners for every width
    for (int n = 0; n < 8; n++) begin
      a64 = n[2] ? '1 : '0; b64 = n[1] ? '1 : '0; ci64 = n[0];
      a8 = a64[7:0]; b8 = b64[7:0];
      for (int k = 0; k < 4; k++) ci8[k] = n[0];
      @(posedge clk); #1;
      chk_all();
    end

    // random vectors with occasional mid-stream reset pulses
    for (int n = 0; n < 10000; n++) begin
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; ci64 = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) b64 = a64;
      a8 = a64[7:0]; b8 = b64[7:0];
      for (int k = 0; k < 4; k++) ci8[k] = $urandom_range(0, 1);
      if (n % 2500 == 1234) begin
        rst = 1'b1;
        #1 chk_reset_vals("rst_mid");
        @(posedge clk); #1;
        chk_reset_vals("rst_mid_hold");
        rst = 1'b0;
      end
      @(posedge clk); #1;
      chk_all();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
